// File: rtl/ball_motion_sched.sv
// Per-frame motion scheduler: turns VGA frame ticks plus keyboard/wall state
// into exactly one registered motion update per frame over a valid/ready handshake.
module ball_motion_sched #(
    parameter logic [9:0] STEP  = 10'd2,
    parameter logic [7:0] W_KEY = 8'h1A,
    parameter logic [7:0] A_KEY = 8'h04,
    parameter logic [7:0] S_KEY = 8'h16,
    parameter logic [7:0] D_KEY = 8'h07
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [15:0] keycode,
    input  logic        at_top,
    input  logic        at_bottom,
    input  logic        at_left,
    input  logic        at_right,
    input  logic        upd_ready,
    output logic        upd_valid,
    output logic [9:0]  X_Motion,
    output logic [9:0]  Y_Motion,
    output logic [2:0]  dir,
    output logic [7:0]  overrun
);

    typedef enum logic [1:0] {IDLE, SAMPLE, DECIDE, ISSUE} state_t;

    localparam logic [2:0] DIR_STOP  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    localparam logic [9:0] NEG_STEP = ~STEP + 10'd1;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, edge_q;
    logic        frameTick;
    logic [7:0]  key0_q, key0_d, key1_q, key1_d;
    logic [7:0]  prev0_q, prev0_d, prev1_q, prev1_d;
    logic [3:0]  walls_q, walls_d;
    logic [2:0]  dir_q, dir_d;
    logic [9:0]  xMot_q, xMot_d, yMot_q, yMot_d;
    logic        valid_q, valid_d;
    logic [7:0]  overrun_q, overrun_d;

    logic [2:0]  keyDir0, keyDir1, arbDir, bounceDir;
    logic        newPress0, newPress1;

    // Maps a keycode to a direction; anything other than WASD yields STOP.
    function automatic logic [2:0] keyToDir(input logic [7:0] k);
        logic [2:0] d;
        d = DIR_STOP;
        if (k == W_KEY)      d = DIR_UP;
        else if (k == S_KEY) d = DIR_DOWN;
        else if (k == A_KEY) d = DIR_LEFT;
        else if (k == D_KEY) d = DIR_RIGHT;
        return d;
    endfunction

    assign frameTick = sync2_q & ~edge_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            edge_q    <= 1'b0;
            state_q   <= IDLE;
            key0_q    <= 8'h00;
            key1_q    <= 8'h00;
            prev0_q   <= 8'h00;
            prev1_q   <= 8'h00;
            walls_q   <= 4'h0;
            dir_q     <= DIR_STOP;
            xMot_q    <= 10'd0;
            yMot_q    <= 10'd0;
            valid_q   <= 1'b0;
            overrun_q <= 8'h00;
        end else begin
            sync1_q   <= frame_clk;
            sync2_q   <= sync1_q;
            edge_q    <= sync2_q;
            state_q   <= state_d;
            key0_q    <= key0_d;
            key1_q    <= key1_d;
            prev0_q   <= prev0_d;
            prev1_q   <= prev1_d;
            walls_q   <= walls_d;
            dir_q     <= dir_d;
            xMot_q    <= xMot_d;
            yMot_q    <= yMot_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Arbitration works on the sampled registers only, so keycode never reaches outputs combinationally.
    always_comb begin
        keyDir0   = keyToDir(key0_q);
        keyDir1   = keyToDir(key1_q);
        newPress0 = (keyDir0 != DIR_STOP) && (key0_q != prev0_q);
        newPress1 = (keyDir1 != DIR_STOP) && (key1_q != prev1_q);
        if (newPress0)      arbDir = keyDir0;
        else if (newPress1) arbDir = keyDir1;
        else                arbDir = dir_q;

        bounceDir = arbDir;
        case (arbDir)
            DIR_UP:    if (walls_q[3]) bounceDir = DIR_DOWN;
            DIR_DOWN:  if (walls_q[2]) bounceDir = DIR_UP;
            DIR_LEFT:  if (walls_q[1]) bounceDir = DIR_RIGHT;
            DIR_RIGHT: if (walls_q[0]) bounceDir = DIR_LEFT;
            default:   bounceDir = arbDir;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        key0_d    = key0_q;
        key1_d    = key1_q;
        prev0_d   = prev0_q;
        prev1_d   = prev1_q;
        walls_d   = walls_q;
        dir_d     = dir_q;
        xMot_d    = xMot_q;
        yMot_d    = yMot_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        // Ticks arriving while an update is in flight are dropped, not queued.
        if (frameTick && state_q != IDLE && overrun_q != 8'hFF)
            overrun_d = overrun_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (frameTick) state_d = SAMPLE;
            end
            SAMPLE: begin
                key0_d  = keycode[7:0];
                key1_d  = keycode[15:8];
                walls_d = {at_top, at_bottom, at_left, at_right};
                state_d = DECIDE;
            end
            DECIDE: begin
                prev0_d = key0_q;
                prev1_d = key1_q;
                dir_d   = bounceDir;
                xMot_d  = 10'd0;
                yMot_d  = 10'd0;
                case (bounceDir)
                    DIR_UP:    yMot_d = NEG_STEP;
                    DIR_DOWN:  yMot_d = STEP;
                    DIR_LEFT:  xMot_d = NEG_STEP;
                    DIR_RIGHT: xMot_d = STEP;
                    default:   ;
                endcase
                valid_d = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (upd_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign upd_valid = valid_q;
    assign X_Motion  = xMot_q;
    assign Y_Motion  = yMot_q;
    assign dir       = dir_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_ball_motion_sched.sv
// Directed bench for ball_motion_sched: table of per-frame key/wall vectors
// plus hand-written overrun and mid-handshake reset sequences.
module tb_ball_motion_sched;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_clk;
    logic [15:0] keycode;
    logic        at_top, at_bottom, at_left, at_right;
    logic        upd_ready;
    logic        upd_valid;
    logic [9:0]  X_Motion, Y_Motion;
    logic [2:0]  dir;
    logic [7:0]  overrun;

    int checksTotal  = 0;
    int checksPassed = 0;

    typedef struct {
        logic [15:0] key;
        logic [3:0]  walls;
        logic [2:0]  expDir;
        logic [9:0]  expX;
        logic [9:0]  expY;
    } vec_t;

    vec_t vecs[24];

    ball_motion_sched dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .at_top    (at_top),
        .at_bottom (at_bottom),
        .at_left   (at_left),
        .at_right  (at_right),
        .upd_ready (upd_ready),
        .upd_valid (upd_valid),
        .X_Motion  (X_Motion),
        .Y_Motion  (Y_Motion),
        .dir       (dir),
        .overrun   (overrun)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checksTotal++;
        if (actual == expected) checksPassed++;
        else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                      name, actual, actual, expected, expected);
    endtask

    // Raise frame_clk at a negedge and count cycles until upd_valid; 0 means timeout.
    task automatic applyStimulus(input logic [15:0] key, input logic [3:0] walls, output int lat);
        keycode = key;
        {at_top, at_bottom, at_left, at_right} = walls;
        @(negedge Clk);
        frame_clk = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            if (upd_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic pulseFrame();
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        int lat;
        int badHold;
        int beats;
        int waitCnt;

        vecs[0]  = '{16'h0000, 4'b0000, 3'd0, 10'h000, 10'h000};
        vecs[1]  = '{16'h0000, 4'b0000, 3'd0, 10'h000, 10'h000};
        vecs[2]  = '{16'h0000, 4'b0000, 3'd0, 10'h000, 10'h000};
        vecs[3]  = '{16'h001A, 4'b0000, 3'd1, 10'h000, 10'h3FE};
        vecs[4]  = '{16'h001A, 4'b0000, 3'd1, 10'h000, 10'h3FE};
        vecs[5]  = '{16'h001A, 4'b0000, 3'd1, 10'h000, 10'h3FE};
        vecs[6]  = '{16'h001A, 4'b0000, 3'd1, 10'h000, 10'h3FE};
        vecs[7]  = '{16'h0000, 4'b0000, 3'd1, 10'h000, 10'h3FE};
        vecs[8]  = '{16'h001A, 4'b0000, 3'd1, 10'h000, 10'h3FE};
        vecs[9]  = '{16'h0704, 4'b0000, 3'd3, 10'h3FE, 10'h000};
        vecs[10] = '{16'h0704, 4'b0000, 3'd3, 10'h3FE, 10'h000};
        vecs[11] = '{16'h0007, 4'b0000, 3'd4, 10'h002, 10'h000};
        vecs[12] = '{16'h0000, 4'b0001, 3'd3, 10'h3FE, 10'h000};
        vecs[13] = '{16'h0000, 4'b0000, 3'd3, 10'h3FE, 10'h000};
        vecs[14] = '{16'h0007, 4'b0001, 3'd3, 10'h3FE, 10'h000};
        vecs[15] = '{16'h0016, 4'b0000, 3'd2, 10'h000, 10'h002};
        vecs[16] = '{16'h0000, 4'b0100, 3'd1, 10'h000, 10'h3FE};
        vecs[17] = '{16'h0000, 4'b1000, 3'd2, 10'h000, 10'h002};
        vecs[18] = '{16'h0004, 4'b0010, 3'd4, 10'h002, 10'h000};
        vecs[19] = '{16'h1600, 4'b0000, 3'd2, 10'h000, 10'h002};
        vecs[20] = '{16'h0505, 4'b0000, 3'd2, 10'h000, 10'h002};
        vecs[21] = '{16'h1A04, 4'b0000, 3'd3, 10'h3FE, 10'h000};
        vecs[22] = '{16'h1A04, 4'b0000, 3'd3, 10'h3FE, 10'h000};
        vecs[23] = '{16'h1A00, 4'b0000, 3'd3, 10'h3FE, 10'h000};

        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        keycode   = 16'h0000;
        {at_top, at_bottom, at_left, at_right} = 4'b0000;
        upd_ready = 1'b1;
        repeat (3) @(negedge Clk);
        checkOutput("reset valid",   upd_valid, 0);
        checkOutput("reset dir",     dir, 0);
        checkOutput("reset X",       X_Motion, 0);
        checkOutput("reset Y",       Y_Motion, 0);
        checkOutput("reset overrun", overrun, 0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Tick lands two cycles after the raise, so valid is seen after the 5th rising edge.
        for (int v = 0; v < 24; v++) begin
            applyStimulus(vecs[v].key, vecs[v].walls, lat);
            checkOutput($sformatf("vec%0d latency", v), lat, 5);
            checkOutput($sformatf("vec%0d dir", v), dir, vecs[v].expDir);
            checkOutput($sformatf("vec%0d X", v), X_Motion, vecs[v].expX);
            checkOutput($sformatf("vec%0d Y", v), Y_Motion, vecs[v].expY);
            frame_clk = 1'b0;
            @(negedge Clk);
            checkOutput($sformatf("vec%0d valid drop", v), upd_valid, 0);
            checkOutput($sformatf("vec%0d overrun", v), overrun, 0);
            repeat (3) @(negedge Clk);
        end

        // Stalled handshake: one pending update, 199 further ticks dropped.
        upd_ready = 1'b0;
        keycode   = 16'h0000;
        {at_top, at_bottom, at_left, at_right} = 4'b0000;
        badHold = 0;
        pulseFrame();
        for (int f = 0; f < 199; f++) begin
            frame_clk = 1'b1;
            repeat (3) begin
                @(negedge Clk);
                if (!upd_valid || dir != 3'd3 || X_Motion != 10'h3FE || Y_Motion != 10'h000) badHold++;
            end
            frame_clk = 1'b0;
            repeat (3) begin
                @(negedge Clk);
                if (!upd_valid || dir != 3'd3 || X_Motion != 10'h3FE || Y_Motion != 10'h000) badHold++;
            end
        end
        checkOutput("stall hold violations", badHold, 0);
        checkOutput("stall overrun", overrun, 199);
        upd_ready = 1'b1;
        beats = 0;
        repeat (8) begin
            if (upd_valid && upd_ready) beats++;
            @(negedge Clk);
        end
        checkOutput("stall beats", beats, 1);
        checkOutput("stall valid after", upd_valid, 0);

        // Drive overrun past 255 to check saturation.
        upd_ready = 1'b0;
        for (int f = 0; f < 100; f++) pulseFrame();
        checkOutput("overrun saturate", overrun, 255);
        upd_ready = 1'b1;
        waitCnt = 0;
        while (upd_valid && waitCnt < 20) begin
            @(negedge Clk);
            waitCnt++;
        end
        checkOutput("saturate drain", upd_valid, 0);

        // Async reset while valid is held: outputs clear before any Clk edge.
        upd_ready = 1'b0;
        applyStimulus(16'h0007, 4'b0000, lat);
        frame_clk = 1'b0;
        checkOutput("pre-reset valid", upd_valid, 1);
        checkOutput("pre-reset dir", dir, 4);
        #1 Reset_n = 1'b0;
        #1;
        checkOutput("async reset valid",   upd_valid, 0);
        checkOutput("async reset dir",     dir, 0);
        checkOutput("async reset X",       X_Motion, 0);
        checkOutput("async reset Y",       Y_Motion, 0);
        checkOutput("async reset overrun", overrun, 0);
        @(negedge Clk);
        Reset_n   = 1'b1;
        upd_ready = 1'b1;
        repeat (2) @(negedge Clk);
        applyStimulus(16'h0000, 4'b0000, lat);
        checkOutput("post-reset latency", lat, 5);
        checkOutput("post-reset dir", dir, 0);
        frame_clk = 1'b0;
        @(negedge Clk);
        checkOutput("post-reset valid drop", upd_valid, 0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
